weight_loader: RTL and testbench
================================

# weight_loader

Two-phase weight staging buffer between the weight DMA stream and the systolic array's weight-shift inputs, driven by the global controller's `ctrl_weight_dma_req` and `ctrl_weight_load_en`. During phase 1 it accepts 24 64-bit AXI-Stream beats into a ROWS×COLS int8 tile buffer. During phase 2 it emits one full array row per cycle to the array. It also reports fill/protocol errors as sticky flags.

## Interface
- `ROWS`, 12, array rows per tile (rows emitted in phase 2)
- `COLS`, 16, int8 weights per row
- `DW`, 64, DMA beat width; `BEATS_PER_ROW` = COLS*8/DW = 2, `TOTAL_BEATS` = ROWS*BEATS_PER_ROW = 24
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ctrl_weight_dma_req`  in  1  phase 1 enable, from global controller
- `ctrl_weight_load_en`  in  1  phase 2 enable, from global controller
- `s_axis_tdata`  in  DW  weight beat, byte k = weight (beat_idx*8 + k) of the tile, row-major
- `s_axis_tvalid`  in  1  beat valid
- `s_axis_tlast`  in  1  last beat of tile
- `s_axis_tready`  out  1  beat accepted when tvalid&tready
- `w_row_data`  out  COLS*8  row to array; byte c = column c
- `w_row_valid`  out  1  w_row_data valid this cycle
- `w_row_idx`  out  4  index of the row on w_row_data
- `buf_full`  out  1  all TOTAL_BEATS beats captured
- `err_short_fill`  out  1  sticky: load started with buffer not full
- `err_tlast`  out  1  sticky: tlast on a beat other than 23, or missing on beat 23
- `err_conflict`  out  1  sticky: dma_req and load_en high in the same cycle

## Operation
- States: IDLE, FILL, LOADED, EMIT.
- IDLE→FILL when dma_req=1. On that transition: beat_cnt←0, row_cnt←0, buffer cleared to zero, all err flags cleared, buf_full←0.
- FILL: `s_axis_tready` = dma_req & (beat_cnt < TOTAL_BEATS), combinational. Each handshake writes tdata into row beat_cnt/2, half beat_cnt%2 (half 0 = columns 0..7), then beat_cnt++.
- FILL → LOADED when beat 23 is accepted; buf_full←1 on the same edge.
- FILL → EMIT if load_en=1 before full. err_short_fill←1; the missing weights emit as zero.
- dma_req dropping in FILL without load_en: stay in FILL. A later dma_req resumes at the current beat_cnt.
- LOADED: tready=0, so extra beats are not consumed. load_en=1 → EMIT.
- EMIT, each cycle with load_en=1 and row_cnt < ROWS: row[row_cnt] registered onto w_row_data, w_row_idx←row_cnt, w_row_valid←1, row_cnt++. Rows are emitted ascending, 0..ROWS-1.
- EMIT → IDLE after row ROWS-1 is issued. load_en beyond ROWS rows is ignored (valid=0).
- load_en low mid-EMIT pauses emission; emission resumes at row_cnt.
- Conflict: dma_req=1 & load_en=1 in FILL or LOADED sets err_conflict. dma_req wins, so the cycle counts as a fill cycle and no row is emitted.
- err_tlast is evaluated on every accepted beat.
- Buffer contents are retained in IDLE until the next fill starts.

## Timing
- Reset values: tready=0, w_row_data=0, w_row_valid=0, w_row_idx=0, buf_full=0, all err=0, state=IDLE.
- Reset mid-operation discards the partial tile.
- Beat-to-buffer write latency: 1 edge.
- tready can assert in the first dma_req cycle: in IDLE, tready = dma_req, and beat 0 is written.
- load_en sampled high at cycle N → w_row_valid/data at N+1.
- With the controller's nominal 24-cycle phase 1 followed by 12-cycle phase 2, rows appear on 12 consecutive cycles starting 1 cycle after load_en rises.
- w_row_valid deasserts the cycle after the last row.

## Structure
- Shared package (`deit_pkg`): ROWS, COLS, DW, derived BEATS_PER_ROW/TOTAL_BEATS, state encoding localparams, int8 weight type.
- One sub-module: `weight_tile_ram`. It has ROWS entries of COLS*8 bits, a half-row write with byte-lane enables, a registered full-row read, and a synchronous clear.
- All FSM, counters, error logic and the AXI handshake stay in `weight_loader`.

## Test plan
- Nominal tile: dma_req for 24 cycles with tvalid always high and byte = beat*8+k, tlast on beat 23 → 24 handshakes, buf_full at edge 24. Then load_en for 12 cycles → rows 0..11 on consecutive cycles, row r byte c = r*16+c, no err flags.
- Backpressured DMA: tvalid toggles 1/0, dma_req held until buffer full → correct tile, beat_cnt advances only on handshakes, tready drops after beat 23 while tvalid stays high.
- Short fill: dma_req for 24 cycles but only 20 beats sent, then load_en → err_short_fill=1. Rows 0..9 correct, rows 10..11 all zero.
- tlast errors: tlast on beat 5 → err_tlast=1. A fresh tile then clears err_tlast, and a tile with no tlast on beat 23 sets it again.
- Conflict and pause: dma_req & load_en overlap 1 cycle in LOADED → err_conflict=1 and no row is emitted. load_en high 4 cycles, low 3, then high → rows 0..3, gap, then rows 4..11.
- Async reset asserted mid-EMIT after row 5 → all outputs 0 immediately. A subsequent full tile load/emit works normally.

Source files
------------

// File: rtl/deit_pkg.sv
// deit_pkg: tile geometry, FSM encoding and weight type shared by the weight loader slice.
package deit_pkg;
   localparam int ROWS          = 12;
   localparam int COLS          = 16;
   localparam int DW            = 64;
   localparam int BEATS_PER_ROW = COLS * 8 / DW;
   localparam int TOTAL_BEATS   = ROWS * BEATS_PER_ROW;
   localparam int RW            = $clog2(ROWS);
   localparam int BW            = $clog2(TOTAL_BEATS + 1);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FILL   = 2'd1;
   localparam logic [1:0] ST_LOADED = 2'd2;
   localparam logic [1:0] ST_EMIT   = 2'd3;
   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      FILL   = ST_FILL,
      LOADED = ST_LOADED,
      EMIT   = ST_EMIT
   } state_t;
   typedef logic signed [7:0] weight_t;
endpackage

// File: rtl/weight_loader_if.sv
// weight_loader_if: AXI-Stream weight beat channel from the DMA.
interface weight_loader_if;
   import deit_pkg::*;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tlast;
   logic          tready;
   modport master (output tdata, tvalid, tlast, input tready);
   modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/weight_tile_ram.sv
// weight_tile_ram: ROWS x COLS*8 tile store, byte-lane half-row writes, registered row read.
module weight_tile_ram
   import deit_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              we,
   input  logic [RW-1:0]     wr_addr,
   input  logic [COLS-1:0]   wr_be,
   input  logic [COLS*8-1:0] wr_data,
   input  logic              re,
   input  logic [RW-1:0]     rd_addr,
   output logic [COLS*8-1:0] rd_data
);
   logic [COLS*8-1:0] mem [ROWS];
   // a write in the clearing cycle lands on top of the cleared tile
   always_ff @(posedge clk) begin
      if (clr)
         for (int r = 0; r < ROWS; r++) mem[r] <= '0;
      if (we)
         for (int b = 0; b < COLS; b++)
            if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_data <= '0;
      else if (re)
         rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/weight_loader.sv
// weight_loader: two-phase weight staging buffer; DMA beats fill a tile, rows stream to the array.
module weight_loader
   import deit_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ctrl_weight_dma_req,
   input  logic              ctrl_weight_load_en,
   weight_loader_if.slave    s_axis,
   output logic [COLS*8-1:0] w_row_data,
   output logic              w_row_valid,
   output logic [3:0]        w_row_idx,
   output logic              buf_full,
   output logic              err_short_fill,
   output logic              err_tlast,
   output logic              err_conflict
);
   state_t        state;
   logic [BW-1:0] beat_cnt;
   logic [BW-1:0] wr_idx;
   logic [RW-1:0] row_cnt;
   logic          dma, ld, hs, last_beat, tl_err, emit, clr;
   logic [COLS-1:0] wr_be;
   assign dma       = ctrl_weight_dma_req;
   assign ld        = ctrl_weight_load_en;
   // the first dma_req cycle in IDLE already accepts beat 0
   assign wr_idx    = (state == IDLE) ? '0 : beat_cnt;
   assign s_axis.tready = dma & ((state == IDLE) | ((state == FILL) & (beat_cnt < BW'(TOTAL_BEATS))));
   assign hs        = s_axis.tvalid & s_axis.tready;
   assign last_beat = wr_idx == BW'(TOTAL_BEATS - 1);
   assign tl_err    = hs & (s_axis.tlast != last_beat);
   assign clr       = (state == IDLE) & dma;
   assign emit      = ld & ((state == EMIT) | (~dma & ((state == FILL) | (state == LOADED))));
   assign wr_be     = wr_idx[0] ? {{(COLS/2){1'b1}}, {(COLS/2){1'b0}}} : {{(COLS/2){1'b0}}, {(COLS/2){1'b1}}};
   weight_tile_ram u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .we      (hs),
      .wr_addr (wr_idx[BW-1:1]),
      .wr_be   (wr_be),
      .wr_data ({2{s_axis.tdata}}),
      .re      (emit),
      .rd_addr (row_cnt),
      .rd_data (w_row_data)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         beat_cnt       <= '0;
         row_cnt        <= '0;
         w_row_valid    <= 1'b0;
         w_row_idx      <= '0;
         buf_full       <= 1'b0;
         err_short_fill <= 1'b0;
         err_tlast      <= 1'b0;
         err_conflict   <= 1'b0;
      end else begin
         w_row_valid <= emit;
         if (emit) begin
            w_row_idx <= row_cnt;
            row_cnt   <= row_cnt + 1'b1;
         end
         if (hs) beat_cnt <= wr_idx + 1'b1;
         if (tl_err) err_tlast <= 1'b1;
         case (state)
            IDLE: if (dma) begin
               state          <= FILL;
               beat_cnt       <= {{(BW-1){1'b0}}, hs};
               row_cnt        <= '0;
               buf_full       <= 1'b0;
               err_short_fill <= 1'b0;
               err_tlast      <= tl_err;
               err_conflict   <= 1'b0;
            end
            FILL: if (dma) begin
               if (ld) err_conflict <= 1'b1;
               if (hs && last_beat) begin
                  state    <= LOADED;
                  buf_full <= 1'b1;
               end
            end else if (ld) begin
               state          <= EMIT;
               err_short_fill <= 1'b1;
            end
            LOADED: if (dma && ld) err_conflict <= 1'b1;
                    else if (ld) state <= EMIT;
            EMIT: if (emit && row_cnt == RW'(ROWS - 1)) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: randomized scenarios checked cycle by cycle against a tile-level reference model.
module tb_weight_loader;
   import deit_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dma = 1'b0;
   logic ld = 1'b0;
   logic [COLS*8-1:0] w_row_data;
   logic w_row_valid, buf_full, err_short_fill, err_tlast, err_conflict;
   logic [3:0] w_row_idx;
   int n_chk = 0;
   int n_fail = 0;
   weight_loader_if ax ();
   always #5 clk = ~clk;
   weight_loader dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .ctrl_weight_dma_req (dma),
      .ctrl_weight_load_en (ld),
      .s_axis              (ax),
      .w_row_data          (w_row_data),
      .w_row_valid         (w_row_valid),
      .w_row_idx           (w_row_idx),
      .buf_full            (buf_full),
      .err_short_fill      (err_short_fill),
      .err_tlast           (err_tlast),
      .err_conflict        (err_conflict)
   );
   // reference model: weights indexed by position in the tile, plus phase flags
   logic [7:0] tile [ROWS*COLS];
   logic filling = 0, loaded = 0, emitting = 0;
   int nb = 0, nr = 0;
   logic e_full = 0, e_short = 0, e_tl = 0, e_conf = 0, e_valid = 0;
   logic [3:0] e_idx = '0;
   logic [COLS*8-1:0] e_data = '0;
   task automatic check(input string tag, input logic [COLS*8-1:0] got, input logic [COLS*8-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic check_outs();
      check("w_row_valid", {127'b0, w_row_valid}, {127'b0, e_valid});
      check("w_row_idx", {124'b0, w_row_idx}, {124'b0, e_idx});
      check("w_row_data", w_row_data, e_data);
      check("buf_full", {127'b0, buf_full}, {127'b0, e_full});
      check("err_short_fill", {127'b0, err_short_fill}, {127'b0, e_short});
      check("err_tlast", {127'b0, err_tlast}, {127'b0, e_tl});
      check("err_conflict", {127'b0, err_conflict}, {127'b0, e_conf});
   endtask
   function automatic int cur_beat();
      return filling ? nb : 0;
   endfunction
   task automatic cyc(input logic d, input logic l, input logic v, input logic t, input logic [DW-1:0] data);
      logic tr, hs, em, f0, l0, e0, i0;
      @(negedge clk);
      dma = d; ld = l; ax.tvalid = v; ax.tlast = t; ax.tdata = data;
      f0 = filling; l0 = loaded; e0 = emitting; i0 = !(f0 || l0 || e0);
      tr = d && (i0 || (f0 && nb < TOTAL_BEATS));
      #1 check("s_axis_tready", {127'b0, ax.tready}, {127'b0, tr});
      @(posedge clk);
      hs = v && tr;
      em = l && (e0 || (!d && (f0 || l0)));
      if (i0 && d) begin
         for (int i = 0; i < ROWS*COLS; i++) tile[i] = 8'h00;
         e_full = 0; e_short = 0; e_tl = 0; e_conf = 0; nb = 0; nr = 0; filling = 1;
      end
      if (hs) begin
         for (int k = 0; k < 8; k++) tile[nb*8 + k] = data[k*8 +: 8];
         if (t != (nb == TOTAL_BEATS - 1)) e_tl = 1;
         nb++;
      end
      e_valid = em;
      if (em) begin
         for (int c = 0; c < COLS; c++) e_data[c*8 +: 8] = tile[nr*COLS + c];
         e_idx = 4'(nr);
         nr++;
      end
      if (f0) begin
         if (d) begin
            if (l) e_conf = 1;
            if (nb == TOTAL_BEATS) begin filling = 0; loaded = 1; e_full = 1; end
         end else if (l) begin
            filling = 0; emitting = 1; e_short = 1;
         end
      end else if (l0) begin
         if (d && l) e_conf = 1;
         else if (l) begin loaded = 0; emitting = 1; end
      end else if (e0 && nr == ROWS) emitting = 0;
      #1 check_outs();
   endtask
   function automatic logic [DW-1:0] pat(input int b);
      logic [DW-1:0] r;
      for (int k = 0; k < 8; k++) r[k*8 +: 8] = 8'(b*8 + k);
      return r;
   endfunction
   // tmode: 0 tlast on beat 23, 1 tlast on beat 5, 2 never
   task automatic fill(input int cycles, input int maxb, input bit toggle, input int tmode, input bit use_pat);
      int b;
      logic v, t;
      for (int i = 0; i < cycles; i++) begin
         b = cur_beat();
         v = (b < maxb || loaded) && (!toggle || i % 2 == 0 || loaded);
         t = (tmode == 0) ? (b == TOTAL_BEATS - 1) : (tmode == 1) ? (b == 5) : 1'b0;
         cyc(1'b1, 1'b0, v, t, use_pat ? pat(b) : {$urandom, $urandom});
      end
   endtask
   task automatic load(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask
   task automatic do_reset();
      #2 rst_n = 1'b0; dma = 1'b0; ld = 1'b0; ax.tvalid = 1'b0;
      filling = 0; loaded = 0; emitting = 0; nb = 0; nr = 0;
      e_full = 0; e_short = 0; e_tl = 0; e_conf = 0; e_valid = 0; e_idx = '0; e_data = '0;
      #1 check_outs();
      check("reset_tready", {127'b0, ax.tready}, 128'b0);
      @(negedge clk) rst_n = 1'b1;
   endtask
   initial begin
      ax.tvalid = 1'b0; ax.tlast = 1'b0; ax.tdata = '0;
      #1 check_outs();
      check("reset_tready", {127'b0, ax.tready}, 128'b0);
      @(negedge clk) rst_n = 1'b1;
      fill(24, 24, 0, 0, 1); load(12); load(2); idle(1);
      fill(52, 24, 1, 0, 0); load(12); idle(2);
      fill(24, 20, 0, 0, 0); load(12); idle(1);
      fill(24, 24, 0, 1, 0); load(12);
      fill(24, 24, 0, 0, 0); load(12);
      fill(24, 24, 0, 2, 0); load(12); idle(1);
      fill(24, 24, 0, 0, 0); cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
      load(4); idle(3); load(8); idle(1);
      fill(24, 24, 0, 0, 0); load(6); do_reset();
      fill(24, 24, 0, 0, 0); load(12); idle(2);
      for (int i = 0; i < 600; i++) begin
         int b = cur_beat();
         logic t = ($urandom_range(0, 15) == 0) ? 1'b1 : (b == TOTAL_BEATS - 1);
         cyc(($urandom_range(0, 3) != 0) ^ emitting, $urandom_range(0, 2) == 0 || emitting,
             $urandom_range(0, 3) != 0, t, {$urandom, $urandom});
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
